// File: rtl/stage_if_prefetch_pkg.sv
// Shared widths, fetch step and fetch-entry layout for the prefetching IF stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package stage_if_prefetch_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int INSTR_W_DEF = 32;
    localparam int PC_STEP_DEF = 4;

    // One buffered fetch at the default widths: where it came from and what came back.
    typedef struct packed {
        logic [ADDR_W_DEF-1:0]  addr;
        logic [INSTR_W_DEF-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/stage_if_prefetch_fetch_fifo.sv
// Generic synchronous FIFO holding prefetched {addr, instr} entries, with flush.
// Latency: write at the clock edge, visible on head_dat the following cycle.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
module stage_if_prefetch_fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push  = push && (!full || pop);
    assign do_pop   = pop && !empty;
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign head_dat = mem[rd_ptr];

    // Pointer and occupancy tracking; flush drops everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage array; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/stage_if_prefetch.sv
// Prefetching IF stage: fetch PC, one outstanding imem request, DEPTH-entry buffer to ID.
// Latency: request N -> valid N+2 (N+1 when IF_BYPASS_EN routes a response around an empty buffer).
// Backpressure: freeze holds the head; requests stop once buffer + in-flight reach DEPTH.
module stage_if_prefetch
    import stage_if_prefetch_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                INSTR_W  = INSTR_W_DEF,
    parameter int                DEPTH    = 4,
    parameter int                PC_STEP  = PC_STEP_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_addr,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               valid,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] instruction
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] inflight_addr;
    logic              inflight;
    logic              accept;
    logic              resp_vld;
    logic              push_vld;
    logic              pop_vld;
    logic              head_vld;
    logic [CW-1:0]     fifo_count;
    logic [CW-1:0]     occupancy;
    logic              fifo_full;
    logic              fifo_empty;
    entry_t            fifo_head;
    entry_t            resp_entry;
    entry_t            out_entry;

    // Reserve a slot for every outstanding word so a response can never be dropped.
    assign occupancy = fifo_count + CW'(inflight);
    assign imem_req  = !rst && !branch_taken && !fifo_full && (occupancy < CW'(DEPTH));
    assign imem_addr = fetch_pc;
    assign accept    = imem_req && imem_ready;

    // A response landing in a branch cycle belongs to the old path and is squashed.
    assign resp_vld   = inflight && !branch_taken;
    assign resp_entry = '{addr: inflight_addr, instr: imem_rdata};

`ifdef IF_BYPASS_EN
    logic bypass_vld;
    // Empty buffer: show the fresh word now; it is only buffered if ID is frozen.
    assign bypass_vld = resp_vld && fifo_empty;
    assign push_vld   = resp_vld && !(bypass_vld && !freeze);
    assign head_vld   = !fifo_empty || bypass_vld;
    assign out_entry  = fifo_empty ? resp_entry : fifo_head;
`else
    assign push_vld  = resp_vld;
    assign head_vld  = !fifo_empty;
    assign out_entry = fifo_head;
`endif

    assign pop_vld = !fifo_empty && !freeze;

    // Head presentation; pc reports the successor address, zeroed when nothing is held.
    always_comb begin
        valid       = head_vld;
        pc          = '0;
        instruction = '0;
        if (head_vld) begin
            pc          = out_entry.addr + ADDR_W'(PC_STEP);
            instruction = out_entry.instr;
        end
    end

    // Fetch PC and the single outstanding-request tag; a branch redirects and forgets it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc      <= RESET_PC;
            inflight      <= 1'b0;
            inflight_addr <= '0;
        end else if (branch_taken) begin
            fetch_pc <= branch_addr;
            inflight <= 1'b0;
        end else begin
            inflight <= accept;
            if (accept) begin
                inflight_addr <= fetch_pc;
                fetch_pc      <= fetch_pc + ADDR_W'(PC_STEP);
            end
        end
    end

    stage_if_prefetch_fetch_fifo #(
        .WIDTH (ADDR_W + INSTR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (branch_taken),
        .push     (push_vld),
        .push_dat (resp_entry),
        .pop      (pop_vld),
        .head_dat (fifo_head),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

endmodule

// File: tb/tb_stage_if_prefetch.sv
// Directed cycle-table bench for stage_if_prefetch; memory returns word = address.
// Latency: each table row is one clock cycle, outputs sampled 1 time unit after the falling edge.
// Backpressure: freeze and imem_ready are driven per row from the table.
module tb_stage_if_prefetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b1;
    logic [31:0] imem_rdata = '0;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instruction;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit          rst_first;
        bit          frz;
        bit          br;
        logic [31:0] br_addr;
        bit          rdy;
        bit          exp_req;
        logic [31:0] exp_addr;
        bit          exp_vld;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t vecs[$];

    stage_if_prefetch dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .valid        (valid),
        .pc           (pc),
        .instruction  (instruction)
    );

    always #5 clk = ~clk;

    // Instruction memory: one-cycle read, word content equals its address.
    always @(posedge clk) begin
        if (imem_req && imem_ready) imem_rdata <= imem_addr;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d actual=0x%08h expected=0x%08h", nm, row, act, exp);
        end
    endtask

    task automatic add(input bit rf, input bit f, input bit b, input logic [31:0] ba, input bit r,
                       input bit ereq, input logic [31:0] eaddr, input bit ev,
                       input logic [31:0] epc, input logic [31:0] ein);
        vec_t v;
        v.rst_first = rf; v.frz = f; v.br = b; v.br_addr = ba; v.rdy = r;
        v.exp_req = ereq; v.exp_addr = eaddr; v.exp_vld = ev; v.exp_pc = epc; v.exp_instr = ein;
        vecs.push_back(v);
    endtask

    // Reset is asserted mid-stream to confirm outputs clear without waiting for a clock edge.
    task automatic do_reset(input int row);
        @(negedge clk);
        rst = 1'b1;
        freeze = 1'b0;
        branch_taken = 1'b0;
        imem_ready = 1'b1;
        #1;
        chk("rst_valid", row, {31'b0, valid}, 32'd0);
        chk("rst_pc", row, pc, 32'd0);
        chk("rst_instr", row, instruction, 32'd0);
        chk("rst_req", row, {31'b0, imem_req}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
`ifdef IF_BYPASS_EN
        // Bypass, freeze low: valid one cycle after the request, consumed directly.
        add(1,0,0,0,1, 1,32'd0, 0,32'd0,32'd0);
        add(0,0,0,0,1, 1,32'd4, 1,32'd4,32'd0);
        add(0,0,0,0,1, 1,32'd8, 1,32'd8,32'd4);
        // Bypass, freeze high: same word shown at N+1 and still held at N+2.
        add(1,1,0,0,1, 1,32'd0, 0,32'd0,32'd0);
        add(0,1,0,0,1, 1,32'd4, 1,32'd4,32'd0);
        add(0,1,0,0,1, 1,32'd8, 1,32'd4,32'd0);
`else
        // Streaming from reset: first valid at cycle 2, then one word per cycle.
        add(1,0,0,0,1, 1,32'd0,  0,32'd0, 32'd0);
        add(0,0,0,0,1, 1,32'd4,  0,32'd0, 32'd0);
        add(0,0,0,0,1, 1,32'd8,  1,32'd4, 32'd0);
        add(0,0,0,0,1, 1,32'd12, 1,32'd8, 32'd4);
        add(0,0,0,0,1, 1,32'd16, 1,32'd12,32'd8);
        add(0,0,0,0,1, 1,32'd20, 1,32'd16,32'd12);
        // Freeze for 10 cycles: four requests then stall; release drains with no bubble.
        add(1,1,0,0,1, 1,32'd0,  0,32'd0, 32'd0);
        add(0,1,0,0,1, 1,32'd4,  0,32'd0, 32'd0);
        add(0,1,0,0,1, 1,32'd8,  1,32'd4, 32'd0);
        add(0,1,0,0,1, 1,32'd12, 1,32'd4, 32'd0);
        for (int k = 0; k < 6; k++) add(0,1,0,0,1, 0,32'd16, 1,32'd4, 32'd0);
        add(0,0,0,0,1, 0,32'd16, 1,32'd4, 32'd0);
        add(0,0,0,0,1, 1,32'd16, 1,32'd8, 32'd4);
        add(0,0,0,0,1, 1,32'd20, 1,32'd12,32'd8);
        add(0,0,0,0,1, 1,32'd24, 1,32'd16,32'd12);
        add(0,0,0,0,1, 1,32'd28, 1,32'd20,32'd16);
        // Branch with 3 buffered, 1 in flight, freeze high: flush and restart at 0x100.
        add(1,1,0,0,1, 1,32'd0,  0,32'd0, 32'd0);
        add(0,1,0,0,1, 1,32'd4,  0,32'd0, 32'd0);
        add(0,1,0,0,1, 1,32'd8,  1,32'd4, 32'd0);
        add(0,1,0,0,1, 1,32'd12, 1,32'd4, 32'd0);
        add(0,1,1,32'h100,1, 0,32'd16, 1,32'd4, 32'd0);
        add(0,0,0,0,1, 1,32'h100, 0,32'd0, 32'd0);
        add(0,0,0,0,1, 1,32'h104, 0,32'd0, 32'd0);
        add(0,0,0,0,1, 1,32'h108, 1,32'h104,32'h100);
        add(0,0,0,0,1, 1,32'h10C, 1,32'h108,32'h104);
        // Back-to-back branches: only the second target is ever delivered.
        add(1,0,0,0,1, 1,32'd0,  0,32'd0, 32'd0);
        add(0,0,1,32'h200,1, 0,32'd4, 0,32'd0, 32'd0);
        add(0,0,1,32'h300,1, 0,32'h200, 0,32'd0, 32'd0);
        add(0,0,0,0,1, 1,32'h300, 0,32'd0, 32'd0);
        add(0,0,0,0,1, 1,32'h304, 0,32'd0, 32'd0);
        add(0,0,0,0,1, 1,32'h308, 1,32'h304,32'h300);
        // imem_ready pattern 1,0,0,1 twice: address held, delivery stays sequential.
        add(1,0,0,0,1, 1,32'd0,  0,32'd0, 32'd0);
        add(0,0,0,0,0, 1,32'd4,  0,32'd0, 32'd0);
        add(0,0,0,0,0, 1,32'd4,  1,32'd4, 32'd0);
        add(0,0,0,0,1, 1,32'd4,  0,32'd0, 32'd0);
        add(0,0,0,0,1, 1,32'd8,  0,32'd0, 32'd0);
        add(0,0,0,0,1, 1,32'd12, 1,32'd8, 32'd4);
        add(0,0,0,0,0, 1,32'd16, 1,32'd12,32'd8);
        add(0,0,0,0,0, 1,32'd16, 1,32'd16,32'd12);
        add(0,0,0,0,1, 1,32'd16, 0,32'd0, 32'd0);
        add(0,0,0,0,1, 1,32'd20, 0,32'd0, 32'd0);
        add(0,0,0,0,1, 1,32'd24, 1,32'd20,32'd16);
        // Address wrap at the top of the space.
        add(1,0,1,32'hFFFF_FFFC,1, 0,32'd0, 0,32'd0, 32'd0);
        add(0,0,0,0,1, 1,32'hFFFF_FFFC, 0,32'd0, 32'd0);
        add(0,0,0,0,1, 1,32'd0,  0,32'd0, 32'd0);
        add(0,0,0,0,1, 1,32'd4,  1,32'd0, 32'hFFFF_FFFC);
        add(0,0,0,0,1, 1,32'd8,  1,32'd4, 32'd0);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst_first) do_reset(i);
            else @(negedge clk);
            freeze       = vecs[i].frz;
            branch_taken = vecs[i].br;
            branch_addr  = vecs[i].br_addr;
            imem_ready   = vecs[i].rdy;
            #1;
            chk("imem_req", i, {31'b0, imem_req}, {31'b0, vecs[i].exp_req});
            chk("imem_addr", i, imem_addr, vecs[i].exp_addr);
            chk("valid", i, {31'b0, valid}, {31'b0, vecs[i].exp_vld});
            chk("pc", i, pc, vecs[i].exp_pc);
            chk("instruction", i, instruction, vecs[i].exp_instr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
